// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage pipelined bitwise logic unit with valid/ready
//               handshakes on both sides, optional result chaining into
//               operand A, and registered result flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream presents a transaction
//   in_ready   out  unit can accept a transaction this cycle
//   op         in   operation select (3 bits), sampled with a/b
//   chain      in   1 = previous result replaces operand A
//   a, b       in   operands, WIDTH bits
//   out_valid  out  result and flags valid
//   out_ready  in   downstream accepts the result
//   y          out  result, WIDTH bits
//   zero       out  y == 0
//   all_ones   out  y == all ones
//   parity     out  XOR-reduction of y
//   ones       out  number of set bits in y (CNT_W bits)
// ============================================================================
module logic_unit_pipe #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             chain,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             all_ones,
  output logic             parity,
  output logic [CNT_W-1:0] ones
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_XOR  = 3'b010;
  localparam logic [2:0] c_OP_XNOR = 3'b011;
  localparam logic [2:0] c_OP_NAND = 3'b100;
  localparam logic [2:0] c_OP_NOR  = 3'b101;
  localparam logic [2:0] c_OP_NOTA = 3'b110;
  localparam logic [2:0] c_OP_PASB = 3'b111;

  // Stage 1: captured transaction
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic             r_s1_chain;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2: result, flags and chaining accumulator
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_all_ones;
  logic             r_parity;
  logic [CNT_W-1:0] r_ones;
  logic [WIDTH-1:0] r_acc;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_y;
  logic [CNT_W-1:0] w_ones;

  // Stage 2 can take a new value when empty or when its content leaves now.
  assign w_s2_adv   = !r_s2_valid || out_ready;
  // Stage 1 frees up when empty or when it moves into stage 2 this edge.
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  // acc always holds the result of the transaction most recently loaded into
  // stage 2, i.e. the one just before stage 1 in acceptance order.
  always_comb begin
    w_a_eff = r_s1_chain ? r_acc : r_s1_a;
    case (r_s1_op)
      c_OP_AND:  w_y = w_a_eff & r_s1_b;
      c_OP_OR:   w_y = w_a_eff | r_s1_b;
      c_OP_XOR:  w_y = w_a_eff ^ r_s1_b;
      c_OP_XNOR: w_y = ~(w_a_eff ^ r_s1_b);
      c_OP_NAND: w_y = ~(w_a_eff & r_s1_b);
      c_OP_NOR:  w_y = ~(w_a_eff | r_s1_b);
      c_OP_NOTA: w_y = ~w_a_eff;
      c_OP_PASB: w_y = r_s1_b;
      default:   w_y = r_s1_b;
    endcase
  end

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + CNT_W'(w_y[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_chain <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op    <= op;
        r_s1_chain <= chain;
        r_s1_a     <= a;
        r_s1_b     <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_zero     <= 1'b0;
      r_all_ones <= 1'b0;
      r_parity   <= 1'b0;
      r_ones     <= '0;
      r_acc      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y        <= w_y;
        r_zero     <= (w_y == '0);
        r_all_ones <= &w_y;
        r_parity   <= ^w_y;
        r_ones     <= w_ones;
        r_acc      <= w_y;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign all_ones  = r_all_ones;
  assign parity    = r_parity;
  assign ones      = r_ones;

endmodule
`default_nettype wire
